// File: rtl/fpu_norm_round_pkg.sv
// Shared float format constants, status bit positions, FSM states and the raw-sum record
// passed from the adder core into the normalise/round stage.
package fpu_norm_round_pkg;

  localparam int unsigned EXP_W  = 6;
  localparam int unsigned FRAC_W = 25;
  localparam int unsigned BIAS   = 31;
  localparam int unsigned MANT_W = FRAC_W + 5;

  localparam int unsigned STATUS_EXACT     = 3;
  localparam int unsigned STATUS_OVERFLOW  = 2;
  localparam int unsigned STATUS_UNDERFLOW = 1;
  localparam int unsigned STATUS_INEXACT   = 0;

  localparam logic signed [EXP_W+1:0] EXP_MAX  = (EXP_W+2)'((2**EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;
  localparam logic signed [EXP_W+1:0] EXP_ONE  = (EXP_W+2)'(1);

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    ROUND,
    PACK,
    DONE
  } norm_state_t;

  typedef struct packed {
    logic                    sign;
    logic signed [EXP_W+1:0] exp;
    logic [MANT_W-1:0]       mant;
  } raw_sum_t;

endpackage

// File: rtl/fpu_norm_round_if.sv
// Handshake bus between the adder core, the normalise/round stage and its consumer.
interface fpu_norm_round_if;
  import fpu_norm_round_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic signed [EXP_W+1:0] in_exp;
  logic [MANT_W-1:0]       in_mant;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             data_out;
  logic [3:0]              status_out;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, data_out, status_out
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, data_out, status_out
  );

endinterface

// File: rtl/fpu_norm_round_rne_round.sv
// Round-to-nearest-even of a stored fraction using its guard/round/sticky bits.
module fpu_rne_round
  import fpu_norm_round_pkg::*;
(
  input  logic [FRAC_W-1:0] frac,
  input  logic [2:0]        grs,
  output logic [FRAC_W-1:0] frac_out,
  output logic              carry_out,
  output logic              inexact
);

  logic inc;

  always_comb begin
    inc                   = grs[2] & (grs[1] | grs[0] | frac[0]);
    {carry_out, frac_out} = {1'b0, frac} + {{FRAC_W{1'b0}}, inc};
    inexact               = |grs;
  end

endmodule

// File: rtl/fpu_norm_round.sv
// Post-add normalise / round-to-nearest-even / pack stage with valid-ready on both sides.
module fpu_norm_round
  import fpu_norm_round_pkg::*;
(
  input logic             clock,
  input logic             reset,
  fpu_norm_round_if.slave bus
);

  norm_state_t             state, state_next;
  raw_sum_t                in_rec;
  logic                    sign_q;
  logic signed [EXP_W+1:0] exp_q;
  logic [MANT_W-1:0]       mant_q;
  logic                    zero_q;
  logic                    inexact_q;
  logic                    carry, hidden;
  logic [FRAC_W-1:0]       rnd_frac;
  logic                    rnd_carry, rnd_inexact;
  logic [31:0]             pack_data;
  logic [3:0]              pack_status;

  always_comb begin
    in_rec = '{sign: bus.in_sign, exp: bus.in_exp, mant: bus.in_mant};
    carry  = mant_q[MANT_W-1];
    hidden = mant_q[MANT_W-2];
  end

  fpu_rne_round u_round (
    .frac      (mant_q[FRAC_W+2:3]),
    .grs       (mant_q[2:0]),
    .frac_out  (rnd_frac),
    .carry_out (rnd_carry),
    .inexact   (rnd_inexact)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_next = (bus.in_mant == '0) ? PACK : NORM;
      NORM:    if (!carry && hidden) state_next = ROUND;
      ROUND:   state_next = PACK;
      PACK:    state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == IDLE);
  end

  // Signed exponent range checks, first match wins.
  always_comb begin
    pack_data   = '0;
    pack_status = '0;
    if (zero_q) begin
      pack_data                 = {sign_q, 31'b0};
      pack_status[STATUS_EXACT] = 1'b1;
    end else if (exp_q >= EXP_MAX) begin
      pack_data                    = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      pack_status[STATUS_OVERFLOW] = 1'b1;
    end else if (exp_q <= EXP_ZERO) begin
      pack_data                     = {sign_q, 31'b0};
      pack_status[STATUS_UNDERFLOW] = 1'b1;
    end else begin
      pack_data = {sign_q, exp_q[EXP_W-1:0], mant_q[FRAC_W+2:3]};
      if (inexact_q) pack_status[STATUS_INEXACT] = 1'b1;
      else           pack_status[STATUS_EXACT]   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sign_q         <= 1'b0;
      exp_q          <= '0;
      mant_q         <= '0;
      zero_q         <= 1'b0;
      inexact_q      <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.data_out   <= '0;
      bus.status_out <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          sign_q    <= in_rec.sign;
          exp_q     <= in_rec.exp;
          mant_q    <= in_rec.mant;
          zero_q    <= (in_rec.mant == '0);
          inexact_q <= 1'b0;
        end
        NORM: begin
          // Right shift folds the dropped round bit into sticky.
          if (carry) begin
            mant_q <= {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
            exp_q  <= exp_q + EXP_ONE;
          end else if (!hidden) begin
            mant_q <= {mant_q[MANT_W-2:0], 1'b0};
            exp_q  <= exp_q - EXP_ONE;
          end
        end
        ROUND: begin
          inexact_q <= rnd_inexact;
          if (rnd_carry) begin
            mant_q <= {2'b01, {FRAC_W{1'b0}}, 3'b000};
            exp_q  <= exp_q + EXP_ONE;
          end else begin
            mant_q <= {2'b01, rnd_frac, 3'b000};
          end
        end
        PACK: begin
          bus.out_valid  <= 1'b1;
          bus.data_out   <= pack_data;
          bus.status_out <= pack_status;
        end
        DONE: if (bus.out_ready) bus.out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_norm_round.sv
// Directed bench for fpu_norm_round: arithmetic reference model, per-cycle output compare,
// handshake hold and mid-operation reset.
module tb_fpu_norm_round;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   accept_cyc = 0;
  bit   seen = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  status;
    int          lat;
  } exp_t;

  typedef struct {
    logic              s;
    logic signed [7:0] e;
    logic [29:0]       m;
    logic [31:0]       d;
    logic [3:0]        st;
    int                lat;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[15];

  fpu_norm_round_if bus ();

  fpu_norm_round dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Value-level reference: locate the leading one, align it to the hidden position,
  // round the discarded bits to nearest-even, then classify the exponent.
  function automatic exp_t model(input logic s, input logic signed [7:0] e8, input logic [29:0] m);
    exp_t   r;
    longint v, sig;
    int     e, k, p, rem;
    e = e8;
    v = longint'(m);
    if (m == 0) begin
      r.data = {s, 31'b0}; r.status = 4'b1000; r.lat = 1;
      return r;
    end
    p = 29;
    while (((v >> p) & 1) == 0) p--;
    if (p == 29) begin
      v = (v >> 1) | (v & 1); e = e + 1; k = 1;
    end else begin
      k = 28 - p; v = v << k; e = e - k;
    end
    rem = int'(v & 7);
    sig = v >> 3;
    if (rem > 4 || (rem == 4 && (sig & 1) == 1)) sig = sig + 1;
    if (sig >= (64'sd1 << 26)) begin
      sig = sig >> 1; e = e + 1;
    end
    r.lat = k + 3;
    if (e >= 63) begin
      r.data = {s, 6'h3F, 25'b0}; r.status = 4'b0100;
    end else if (e <= 0) begin
      r.data = {s, 31'b0}; r.status = 4'b0010;
    end else begin
      r.data   = {s, 6'(e), 25'(sig)};
      r.status = (rem != 0) ? 4'b0001 : 4'b1000;
    end
    return r;
  endfunction

  always @(negedge clock) begin
    if (reset === 1'b1 && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out: out_valid=1 with data %h, required no result pending", bus.data_out);
      end else begin
        if (!seen) chk("latency", 32'(cyc - accept_cyc), 32'(exp_q[0].lat));
        seen = 1'b1;
        chk("data_out", bus.data_out, exp_q[0].data);
        chk("status_out", 32'(bus.status_out), 32'(exp_q[0].status));
        chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input vec_t v);
    int n = 0;
    @(negedge clock);
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clock); n++;
    end
    chk("accept_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_sign  = v.s;
    bus.in_exp   = v.e;
    bus.in_mant  = v.m;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.in_mant  = '0;
    accept_cyc   = cyc;
    exp_q.push_back(model(v.s, v.e, v.m));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock); n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding after %0d cycles, required 0", exp_q.size(), n);
      exp_q.delete();
      seen = 1'b0;
    end
  endtask

  initial begin
    exp_t r;
    int   n;
    vecs[0]  = '{1'b0,  8'sd31, 30'h1000_0000, 32'h3E00_0000, 4'b1000, 3};
    vecs[1]  = '{1'b0,  8'sd31, 30'h3000_0000, 32'h4100_0000, 4'b1000, 4};
    vecs[2]  = '{1'b0,  8'sd31, 30'h0400_0000, 32'h3A00_0000, 4'b1000, 5};
    vecs[3]  = '{1'b1,  8'sd31, 30'h0000_0000, 32'h8000_0000, 4'b1000, 1};
    vecs[4]  = '{1'b0,  8'sd31, 30'h1000_000C, 32'h3E00_0002, 4'b0001, 3};
    vecs[5]  = '{1'b0,  8'sd31, 30'h1000_0014, 32'h3E00_0002, 4'b0001, 3};
    vecs[6]  = '{1'b0,  8'sd31, 30'h1FFF_FFFC, 32'h4000_0000, 4'b0001, 3};
    vecs[7]  = '{1'b0,  8'sd63, 30'h1000_0000, 32'h7E00_0000, 4'b0100, 3};
    vecs[8]  = '{1'b1,  8'sd0,  30'h1000_0000, 32'h8000_0000, 4'b0010, 3};
    vecs[9]  = '{1'b0, -8'sd3,  30'h1000_0000, 32'h0000_0000, 4'b0010, 3};
    vecs[10] = '{1'b0,  8'sd62, 30'h1FFF_FFFC, 32'h7E00_0000, 4'b0100, 3};
    vecs[11] = '{1'b0,  8'sd1,  30'h1000_0000, 32'h0200_0000, 4'b1000, 3};
    vecs[12] = '{1'b0,  8'sd1,  30'h0800_0000, 32'h0000_0000, 4'b0010, 4};
    vecs[13] = '{1'b0,  8'sd31, 30'h3000_000C, 32'h4100_0001, 4'b0001, 4};
    vecs[14] = '{1'b1,  8'sd31, 30'h0000_0001, 32'h8600_0000, 4'b1000, 31};

    for (int i = 0; i < 15; i++) begin
      r = model(vecs[i].s, vecs[i].e, vecs[i].m);
      chk($sformatf("model_data[%0d]", i), r.data, vecs[i].d);
      chk($sformatf("model_status[%0d]", i), 32'(r.status), 32'(vecs[i].st));
      chk($sformatf("model_lat[%0d]", i), 32'(r.lat), 32'(vecs[i].lat));
    end

    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_mant   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_data_out", bus.data_out, 32'd0);
    chk("reset_status_out", 32'(bus.status_out), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      send(vecs[i]);
      wait_drain();
    end

    // Consumer stall: output must hold while out_ready is low.
    bus.out_ready = 1'b0;
    send(vecs[4]);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      @(negedge clock); n++;
    end
    chk("hold_valid_seen", 32'(bus.out_valid), 32'd1);
    repeat (10) @(negedge clock);
    @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("release_data_kept", bus.data_out, 32'h3E00_0002);
    chk("release_status_kept", 32'(bus.status_out), 32'b0001);
    wait_drain();

    // Abort a long normalisation with reset.
    send(vecs[14]);
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_data_out", bus.data_out, 32'd0);
    exp_q.delete();
    seen = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    chk("abort_idle_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_idle_ready", 32'(bus.in_ready), 32'd1);

    send(vecs[13]);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
